// File: rtl/fixed_to_float_normalizer_if.sv
// Handshake and result bus between the conversion controller and the
// fixed-to-float normalizer.
interface fixed_to_float_normalizer_if;
  localparam int unsigned W = 32;
  localparam int unsigned ENCD_W = 8;

  logic              START;
  logic [W-1:0]      FIXED;
  logic [W-1:0]      FLOAT;
  logic [ENCD_W-1:0] ENCD;
  logic              BANDCOMP;
  logic              BUSY;
  logic              ACK;

  modport master (output START, FIXED, input FLOAT, ENCD, BANDCOMP, BUSY, ACK);
  modport slave  (input START, FIXED, output FLOAT, ENCD, BANDCOMP, BUSY, ACK);
endinterface

// File: rtl/fixed_to_float_normalizer.sv
// Fixed-point to IEEE-754 single normalizer: bit-serial leading-one scan,
// single-cycle barrel normalize, pack. Define FTF_ROUND_NEAREST_EN for
// round-to-nearest-even on the residue; otherwise the residue is truncated.
module fixed_to_float_normalizer #(
  parameter int unsigned W    = 32,
  parameter int unsigned FRAC = 26
) (
  input logic                      CLK,
  input logic                      RST_N,
  fixed_to_float_normalizer_if.slave bus
);

  typedef enum logic [2:0] {IDLE, SCAN, NORM, PACK, DONE} state_t;

  state_t       state, state_nxt;
  logic         sign, sign_nxt;
  logic [W-1:0] mag, mag_nxt;
  logic [4:0]   idx, idx_nxt;
  logic [7:0]   encd, encd_nxt;
  logic         band, band_nxt;
  logic         zero, zero_nxt;
  logic [W-1:0] flt, flt_nxt;
  logic         ack, busy;

  logic [7:0]   exp_raw, exp_fin;
  logic [22:0]  mant_fin;
  logic [W-1:0] packed_word;

  // Exponent/mantissa assembly from the normalized magnitude
  always_comb begin
    exp_raw = 8'(32'(encd) + 32'd127 - 32'(FRAC));
`ifdef FTF_ROUND_NEAREST_EN
    begin
      logic        round_up;
      logic [23:0] mant_sum;
      round_up = mag[7] & ((|mag[6:0]) | mag[8]);
      mant_sum = {1'b0, mag[30:8]} + 24'(round_up);
      // A carry out leaves the low 23 bits at zero, which is exactly the
      // renormalized mantissa; only the exponent needs the bump.
      mant_fin = mant_sum[22:0];
      exp_fin  = exp_raw + 8'(mant_sum[23]);
    end
`else
    mant_fin = mag[30:8];
    exp_fin  = exp_raw;
`endif
    packed_word = zero ? '0 : {sign, exp_fin, mant_fin};
  end

  // Next-state and datapath update
  always_comb begin
    state_nxt = state;
    sign_nxt  = sign;
    mag_nxt   = mag;
    idx_nxt   = idx;
    encd_nxt  = encd;
    band_nxt  = band;
    zero_nxt  = zero;
    flt_nxt   = flt;
    unique case (state)
      IDLE: begin
        if (bus.START) begin
          sign_nxt  = bus.FIXED[31];
          // 0x80000000 negates to itself, which read unsigned is 2^31
          mag_nxt   = bus.FIXED[31] ? W'(~bus.FIXED + W'(1)) : bus.FIXED;
          idx_nxt   = 5'd31;
          zero_nxt  = 1'b0;
          state_nxt = SCAN;
        end
      end
      SCAN: begin
        if (mag[idx]) begin
          encd_nxt  = 8'(idx);
          band_nxt  = 32'(idx) > 32'(FRAC);
          state_nxt = NORM;
        end else if (idx == 5'd0) begin
          encd_nxt  = 8'd0;
          band_nxt  = 1'b0;
          zero_nxt  = 1'b1;
          state_nxt = PACK;
        end else begin
          idx_nxt = idx - 5'd1;
        end
      end
      NORM: begin
        mag_nxt   = mag << (5'd31 - encd[4:0]);
        state_nxt = PACK;
      end
      PACK: begin
        flt_nxt   = packed_word;
        state_nxt = DONE;
      end
      DONE: begin
        if (!bus.START) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and datapath registers, synchronous active-low reset
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state <= IDLE;
      sign  <= 1'b0;
      mag   <= '0;
      idx   <= 5'd0;
      encd  <= 8'd0;
      band  <= 1'b0;
      zero  <= 1'b0;
      flt   <= '0;
      ack   <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      sign  <= sign_nxt;
      mag   <= mag_nxt;
      idx   <= idx_nxt;
      encd  <= encd_nxt;
      band  <= band_nxt;
      zero  <= zero_nxt;
      flt   <= flt_nxt;
      ack   <= (state_nxt == DONE);
      busy  <= (state_nxt != IDLE);
    end
  end

  assign bus.FLOAT    = flt;
  assign bus.ENCD     = encd;
  assign bus.BANDCOMP = band;
  assign bus.BUSY     = busy;
  assign bus.ACK      = ack;

endmodule

// File: tb/tb_fixed_to_float_normalizer.sv
// Randomized self-checking bench for fixed_to_float_normalizer.
module tb_fixed_to_float_normalizer;
  localparam int unsigned FRAC = 26;

  logic CLK = 1'b0;
  logic RST_N;
  int   n_cmp = 0;
  int   n_err = 0;

  fixed_to_float_normalizer_if bus ();

  fixed_to_float_normalizer #(.W(32), .FRAC(FRAC)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference: value = fixed * 2^-FRAC, converted from the magnitude's top bit
  function automatic void model(input logic [31:0] x, output logic [31:0] f,
                                output int p, output bit bc);
    longint m, q, rem, half;
    int e;
    m = longint'($signed(x));
    if (m < 0) m = -m;
    p = 0; bc = 0; f = 32'd0;
    if (m == 0) return;
    while ((m >> (p + 1)) != 0) p++;
    bc = (p > int'(FRAC));
    rem = 0; half = 0;
    if (p >= 23) begin
      q   = m >> (p - 23);
      rem = m - (q << (p - 23));
      if (p > 23) half = longint'(1) << (p - 24);
    end else begin
      q = m << (23 - p);
    end
    e = p - int'(FRAC) + 127;
`ifdef FTF_ROUND_NEAREST_EN
    if (p > 23 && (rem > half || (rem == half && q[0]))) q++;
    if (q == (longint'(1) << 24)) begin
      q = longint'(1) << 23;
      e++;
    end
`endif
    f = {x[31], 8'(e), 23'(q)};
  endfunction

  // One full four-phase conversion; optionally scrambles inputs while busy
  task automatic convert(input logic [31:0] x, input bit glitch, input int hold);
    logic [31:0] ef;
    int ep, lat, cnt;
    bit eb;
    model(x, ef, ep, eb);
    lat = (ep == 0 && ef == 32'd0) ? 33 : 34 - ep;
    @(negedge CLK);
    bus.START = 1'b1;
    bus.FIXED = x;
    @(posedge CLK);
    @(negedge CLK);
    chk("busy_e0", 32'(bus.BUSY), 32'd1);
    cnt = 0;
    while (!bus.ACK && cnt < 40) begin
      if (glitch) begin
        bus.START = 1'($urandom);
        bus.FIXED = $urandom;
      end
      @(posedge CLK);
      cnt++;
      @(negedge CLK);
    end
    bus.START = 1'b1;
    chk("latency", 32'(cnt), 32'(lat));
    chk("float", bus.FLOAT, ef);
    chk("encd", 32'(bus.ENCD), 32'(ep));
    chk("bandcomp", 32'(bus.BANDCOMP), 32'(eb));
    repeat (hold) @(negedge CLK);
    chk("ack_hold", 32'(bus.ACK), 32'd1);
    bus.START = 1'b0;
    @(negedge CLK);
    chk("ack_drop", 32'(bus.ACK), 32'd0);
    chk("busy_idle", 32'(bus.BUSY), 32'd0);
    chk("float_held", bus.FLOAT, ef);
  endtask

  initial begin
    logic [31:0] v;
    RST_N = 1'b0;
    bus.START = 1'b0;
    bus.FIXED = 32'd0;
    repeat (3) @(negedge CLK);
    chk("rst_float", bus.FLOAT, 32'd0);
    chk("rst_ctl", {28'd0, bus.ENCD[0], bus.BANDCOMP, bus.BUSY, bus.ACK}, 32'd0);
    RST_N = 1'b1;

    convert(32'h0400_0000, 1'b0, 0);
    convert(32'hFC00_0000, 1'b0, 0);
    convert(32'h8000_0000, 1'b0, 0);
    convert(32'h0000_0000, 1'b0, 5);
    convert(32'h7FFF_FFFF, 1'b0, 0);
    convert(32'h0000_0001, 1'b0, 0);
    convert(32'h0000_0180, 1'b1, 1);

    // Reset in the middle of a long scan
    @(negedge CLK);
    bus.START = 1'b1;
    bus.FIXED = 32'h0000_0001;
    @(posedge CLK);
    repeat (9) @(negedge CLK);
    RST_N = 1'b0;
    bus.START = 1'b0;
    @(negedge CLK);
    chk("midrst_float", bus.FLOAT, 32'd0);
    chk("midrst_encd", 32'(bus.ENCD), 32'd0);
    chk("midrst_ctl", {29'd0, bus.BANDCOMP, bus.BUSY, bus.ACK}, 32'd0);
    RST_N = 1'b1;
    convert(32'h0123_4567, 1'b1, 0);

    for (int i = 0; i < 40; i++) begin
      v = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) v = -v;
      convert(v, 1'($urandom), int'($urandom_range(0, 2)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
